instruction_fetch: RTL and testbench

- PC generation and fetch-request stage sitting directly upstream of the 2-way instruction cache.
- Issues one word read per request to the cache and waits for its registered hit/data response.
- On a miss, backs off for a fixed interval and re-requests the same PC; the cache fills on miss, so the retry hits.
- Buffers returned instructions with their PCs in a 2-entry FIFO toward decode (valid/ready).
- Accepts branch redirects from execute.

---
 rtl/instruction_fetch.sv | 179 +++++++++++++++++
 tb/tb_instruction_fetch.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// PC generation and fetch-request stage feeding a word-addressed instruction cache.
// Retries the same PC after a fixed back-off on a miss and queues fetched words to decode.
module instruction_fetch #(
    parameter int unsigned          DATAWIDTH = 32'd32,
    parameter logic [DATAWIDTH-1:0] RESET_PC  = {DATAWIDTH{1'b0}},
    parameter logic [DATAWIDTH-1:0] PC_STEP   = {{(DATAWIDTH-1){1'b0}}, 1'b1},
    parameter int unsigned          MISS_WAIT = 32'd2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 fetch_enable,
    input  logic                 redirect_valid,
    input  logic [DATAWIDTH-1:0] redirect_pc,
    output logic                 ic_read,
    output logic [DATAWIDTH-1:0] ic_address,
    input  logic                 ic_hit,
    input  logic [DATAWIDTH-1:0] ic_data,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [DATAWIDTH-1:0] inst,
    output logic [DATAWIDTH-1:0] inst_pc,
    output logic [15:0]          miss_count
);

    typedef enum logic [1:0] {
        ST_ISSUE     = 2'd0,
        ST_RESP      = 2'd1,
        ST_MISS_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(MISS_WAIT - 32'd1);

    state_t               state_r;
    logic [DATAWIDTH-1:0] pc_r;
    logic [3:0]           wait_cnt_r;
    logic [15:0]          miss_count_r;
    logic [1:0]           count_r;
    logic [DATAWIDTH-1:0] head_inst_r;
    logic [DATAWIDTH-1:0] head_pc_r;
    logic [DATAWIDTH-1:0] tail_inst_r;
    logic [DATAWIDTH-1:0] tail_pc_r;

    logic issue_s;
    logic push_s;
    logic pop_s;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

    // Request, push and pop qualifiers; a redirect suppresses all three.
    always_comb begin
        issue_s = 1'b0;
        push_s  = 1'b0;
        pop_s   = 1'b0;
        if (!reset && !redirect_valid && (state_r == ST_ISSUE) && fetch_enable && (count_r < 2'd2)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        if (!redirect_valid && (state_r == ST_RESP) && ic_hit) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if (!redirect_valid && (count_r != 2'd0) && inst_ready) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Fetch sequencer: PC, state, miss back-off counter and miss statistics.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_ISSUE;
            pc_r         <= RESET_PC;
            wait_cnt_r   <= 4'd0;
            miss_count_r <= 16'd0;
        end else if (redirect_valid) begin
            state_r    <= ST_ISSUE;
            pc_r       <= redirect_pc;
            wait_cnt_r <= 4'd0;
        end else begin
            case (state_r)
                ST_ISSUE: begin
                    if (issue_s) begin
                        state_r <= ST_RESP;
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_RESP: begin
                    if (ic_hit) begin
                        pc_r    <= pc_r + PC_STEP;
                        state_r <= ST_ISSUE;
                    end else begin
                        miss_count_r <= sat_inc16(miss_count_r);
                        wait_cnt_r   <= WAIT_LOAD;
                        state_r      <= ST_MISS_WAIT;
                    end
                end
                ST_MISS_WAIT: begin
                    if (wait_cnt_r == 4'd0) begin
                        state_r <= ST_ISSUE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r    <= ST_ISSUE;
                    wait_cnt_r <= 4'd0;
                end
            endcase
        end
    end

    // Two-entry queue kept as head/tail slots so the head holds its last value once drained.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r     <= 2'd0;
            head_inst_r <= {DATAWIDTH{1'b0}};
            head_pc_r   <= {DATAWIDTH{1'b0}};
            tail_inst_r <= {DATAWIDTH{1'b0}};
            tail_pc_r   <= {DATAWIDTH{1'b0}};
        end else if (redirect_valid) begin
            count_r <= 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_inst_r <= ic_data;
                        head_pc_r   <= pc_r;
                    end else begin
                        tail_inst_r <= ic_data;
                        tail_pc_r   <= pc_r;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    if (count_r == 2'd2) begin
                        head_inst_r <= tail_inst_r;
                        head_pc_r   <= tail_pc_r;
                    end else begin
                        head_inst_r <= head_inst_r;
                        head_pc_r   <= head_pc_r;
                    end
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        head_inst_r <= ic_data;
                        head_pc_r   <= pc_r;
                    end else begin
                        head_inst_r <= tail_inst_r;
                        head_pc_r   <= tail_pc_r;
                        tail_inst_r <= ic_data;
                        tail_pc_r   <= pc_r;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign ic_read    = issue_s;
    assign ic_address = pc_r;
    assign inst_valid = (count_r != 2'd0);
    assign inst       = head_inst_r;
    assign inst_pc    = head_pc_r;
    assign miss_count = miss_count_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; the cache is emulated inside the tick task with
// data = address + 0x100 and an optional one-shot miss at a chosen address.
module tb_instruction_fetch;

    logic        clock;
    logic        reset;
    logic        fetch_enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ic_read;
    logic [31:0] ic_address;
    logic        ic_hit;
    logic [31:0] ic_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [15:0] miss_count;

    int          pass_cnt;
    int          fail_cnt;
    int          total_cnt;
    logic        miss_arm;
    logic [31:0] miss_addr;

    instruction_fetch dut (
        .clock          (clock),
        .reset          (reset),
        .fetch_enable   (fetch_enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ic_read        (ic_read),
        .ic_address     (ic_address),
        .ic_hit         (ic_hit),
        .ic_data        (ic_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .miss_count     (miss_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: capture the request, then present the registered cache response.
    task automatic tick();
        logic        rd;
        logic [31:0] addr;
        #1;
        rd   = ic_read;
        addr = ic_address;
        @(posedge clock);
        #1;
        if (rd && miss_arm && (addr == miss_addr)) begin
            ic_hit   = 1'b0;
            miss_arm = 1'b0;
        end else begin
            ic_hit = rd;
        end
        ic_data = rd ? (addr + 32'h0000_0100) : 32'h0;
    endtask

    initial begin
        pass_cnt = 0; fail_cnt = 0; total_cnt = 0;
        clock = 1'b0; reset = 1'b1;
        fetch_enable = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        ic_hit = 1'b0; ic_data = 32'h0; inst_ready = 1'b1;
        miss_arm = 1'b0; miss_addr = 32'h0;

        // Reset state
        #7;
        chk("rst_ic_read", {31'd0, ic_read}, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_miss_count", {16'd0, miss_count}, 32'd0);
        chk("rst_ic_address", ic_address, 32'h0);
        reset = 1'b0; fetch_enable = 1'b1;
        #1;
        chk("first_read", {31'd0, ic_read}, 32'd1);
        chk("first_addr", ic_address, 32'h0);

        // Streaming hits, one instruction per two cycles
        tick();
        chk("resp_no_read", {31'd0, ic_read}, 32'd0);
        chk("resp_empty", {31'd0, inst_valid}, 32'd0);
        tick();
        chk("hit0_valid", {31'd0, inst_valid}, 32'd1);
        chk("hit0_inst", inst, 32'h100);
        chk("hit0_pc", inst_pc, 32'h0);
        chk("hit0_next_addr", ic_address, 32'h1);
        tick();
        chk("hit0_popped", {31'd0, inst_valid}, 32'd0);
        tick();
        chk("hit1_inst", inst, 32'h101);
        chk("hit1_pc", inst_pc, 32'h1);
        chk("hit1_next_addr", ic_address, 32'h2);

        // Miss at pc 5, back-off, retry hits
        repeat (6) tick();
        chk("pre_miss_addr", ic_address, 32'h5);
        chk("pre_miss_read", {31'd0, ic_read}, 32'd1);
        miss_arm = 1'b1; miss_addr = 32'h5;
        tick();
        tick();
        chk("miss_wait1_read", {31'd0, ic_read}, 32'd0);
        chk("miss_count1", {16'd0, miss_count}, 32'd1);
        tick();
        chk("miss_wait2_read", {31'd0, ic_read}, 32'd0);
        tick();
        chk("retry_read", {31'd0, ic_read}, 32'd1);
        chk("retry_addr", ic_address, 32'h5);
        tick();
        tick();
        chk("retry_inst_pc", inst_pc, 32'h5);
        chk("retry_inst", inst, 32'h105);

        // Redirect during a hitting response discards it and flushes the queue
        inst_ready = 1'b0;
        tick();
        chk("pre_redir_head", inst_pc, 32'h5);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0; inst_ready = 1'b1;
        #1;
        chk("redir_flushed", {31'd0, inst_valid}, 32'd0);
        chk("redir_read", {31'd0, ic_read}, 32'd1);
        chk("redir_addr", ic_address, 32'h40);
        chk("redir_no_miss", {16'd0, miss_count}, 32'd1);

        // Asynchronous reset in the middle of a miss back-off
        miss_arm = 1'b1; miss_addr = 32'h40;
        tick();
        tick();
        chk("miss_count2", {16'd0, miss_count}, 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("async_miss_count", {16'd0, miss_count}, 32'd0);
        chk("async_inst", inst, 32'h0);
        chk("async_inst_pc", inst_pc, 32'h0);
        chk("async_read", {31'd0, ic_read}, 32'd0);
        chk("async_addr", ic_address, 32'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_read", {31'd0, ic_read}, 32'd1);
        chk("post_rst_addr", ic_address, 32'h0);

        // Backpressure: queue fills, issue stalls, then drains in order
        inst_ready = 1'b0;
        repeat (4) tick();
        chk("full_no_read", {31'd0, ic_read}, 32'd0);
        chk("full_head_inst", inst, 32'h100);
        chk("full_head_pc", inst_pc, 32'h0);
        tick();
        chk("full_still_stalled", {31'd0, ic_read}, 32'd0);
        inst_ready = 1'b1;
        tick();
        chk("drain_inst", inst, 32'h101);
        chk("drain_pc", inst_pc, 32'h1);
        chk("resume_read", {31'd0, ic_read}, 32'd1);
        chk("resume_addr", ic_address, 32'h2);
        tick();
        chk("drained", {31'd0, inst_valid}, 32'd0);

        // PC wrap from all-ones to zero
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_addr", ic_address, 32'hFFFF_FFFF);
        chk("wrap_read", {31'd0, ic_read}, 32'd1);
        tick();
        tick();
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFF);
        chk("wrap_inst", inst, 32'h0000_00FF);
        chk("wrap_next_addr", ic_address, 32'h0);
        tick();
        tick();
        chk("wrapped_inst_pc", inst_pc, 32'h0);
        chk("wrapped_inst", inst, 32'h100);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
